adam_aes_stream_drv: RTL and testbench
======================================

# adam_aes_stream_drv

Bus-master sequencer that sits directly upstream of the ADAM AES register-mapped peripheral. It converts a 128-bit valid/ready block stream plus a key/config handshake into the peripheral's single-cycle register accesses. It loads CONFIG and KEY, writes BLOCK, starts the operation and waits for the DONE event. It then clears the event, reads RESULT back, and presents the 128-bit result on an output valid/ready stream.

## Interface
- TIMEOUT_CYCLES, 1024: maximum wait cycles in a polling or waiting state before abort; must be ≥ 2.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cfg_valid / cfg_ready  in / out  1  key/config handshake.
- cfg_key  in  256  key; [255:224] is written first. AES-128 uses [255:128].
- cfg_keylen  in  1  CONFIG bit1 (0 = 128-bit, 1 = 256-bit).
- cfg_encdec  in  1  CONFIG bit0 (1 = encrypt).
- in_valid / in_ready  in / out  1  input block handshake.
- in_block  in  128  plaintext/ciphertext; [127:96] is written first.
- out_valid / out_ready  out / in  1  result handshake.
- out_block  out  128  result; the first RESULT word read goes to [127:96].
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  sticky timeout flag.
- aes_cs, aes_we  out  1  peripheral access strobes.
- aes_address  out  8  register offset.
- aes_write_data  out  32  write data.
- aes_read_data  in  32  combinational read data; valid in the same cycle as aes_cs && !aes_we.
- aes_irq  in  1  peripheral interrupt; used only when AES_DRV_IRQ_EN is defined.

## Operation
- Peripheral register map: CTRL 0x00 (bit0 START, bit1 ENABLE), STATUS 0x04 (bit0 READY), CONFIG 0x08, ER 0x0C (bit0 DONE, W1C), IER 0x10, KEY 0x14 (8 auto-increment writes), BLOCK 0x18 (4 auto-increment writes), RESULT 0x1C (4 auto-increment reads). Writing START rewinds all peripheral word counters.
- Bus rule: at most one access per cycle. aes_cs is high for exactly one cycle per access. aes_address and aes_write_data are registered outputs. Read data is sampled on the clock edge that ends the access.
- FSM states:
  - IDLE. cfg_ready = 1. in_ready = !cfg_valid, so config has priority over blocks. A cfg accept latches key, keylen and encdec, clears err, and goes to CFG. A block accept latches in_block and goes to BLK.
  - CFG. Write CONFIG = {30'b0, keylen, encdec}. With the macro, also write IER = 1. Then go to KEY.
  - KEY. 8 writes to KEY, MSW first, then IDLE.
  - BLK. 4 writes to BLOCK, MSW first, then WAIT_RDY.
  - WAIT_RDY. Read STATUS every cycle until bit0 = 1, then go to START.
  - START. Write CTRL = 0x3, then WAIT_DONE.
  - WAIT_DONE. Without the macro, read ER every cycle until bit0 = 1. With the macro, issue no accesses and wait for aes_irq = 1. Then go to CLR.
  - CLR. Write ER = 0x1, then RES.
  - RES. 4 reads of RESULT, filling out_block MSW first, then OUT.
  - OUT. out_valid = 1 until out_ready, then IDLE.
- Words are always written in the order above. A new key may be loaded between blocks and persists in the peripheral.
- Timeout: a counter clears on entry to WAIT_RDY and to WAIT_DONE and increments each cycle spent there. On reaching TIMEOUT_CYCLES: set err, discard the block, go to IDLE, and emit no output.
- A block issued before any cfg uses the peripheral's reset key/config. This is legal and is not flagged.

## Timing
- Reset values: aes_cs = 0, aes_we = 0, aes_address = 0, aes_write_data = 0, cfg_ready = 1, in_ready = 1, out_valid = 0, out_block = 0, busy = 0, err = 0. The FSM resets to IDLE.
- Reset mid-operation aborts immediately. No bus access is pending after reset deasserts.
- A cfg accept on cycle t produces the first CONFIG write in cycle t+1. The key load is complete at t+10 (t+11 with the macro).
- Polling mode, with STATUS ready immediately and DONE visible on poll k, the block transaction is: accept at t; BLK t+1..t+4; WAIT_RDY t+5; START t+6; polls t+7..t+6+k; CLR t+7+k; RES t+8+k..t+11+k; out_valid from t+12+k.
- out_block is stable while out_valid = 1. in_ready and cfg_ready are 0 whenever busy = 1.

## Configuration
- AES_DRV_IRQ_EN defined: CFG additionally writes IER = 1, and WAIT_DONE waits on aes_irq with no bus traffic.
- AES_DRV_IRQ_EN undefined: no IER write, WAIT_DONE polls ER, and aes_irq is ignored.
- The timeout applies in both builds.

## Structure
- Package adam_aes_drv_pkg holds:
  - register offsets and bit positions;
  - the state enum (IDLE, CFG, KEY, BLK, WAIT_RDY, START, WAIT_DONE, CLR, RES, OUT);
  - word-count constants (KEY_WORDS = 8, BLOCK_WORDS = 4).
- Single module with no sub-module. The word counter (3 bits) and timeout counter ($clog2(TIMEOUT_CYCLES+1) bits) are local.

## Test plan
- FIPS-197 AES-128 encrypt against the real peripheral:
  - Stimulus: cfg key words 00010203, 04050607, 08090a0b, 0c0d0e0f then zeros, keylen = 0, encdec = 1; in_block 00112233445566778899aabbccddeeff.
  - Required response: out_block = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt: same key with encdec = 0; in_block 69c4e0d86a7b0430d8cdb78070b4c55a -> out_block = 00112233445566778899aabbccddeeff.
- Bus trace against a peripheral model: checks the exact address/data sequence, one-cycle aes_cs per access, CTRL write = 0x3, and ER write = 0x1 issued before any RESULT read.
- Simultaneous cfg_valid and in_valid in IDLE: cfg is accepted first and in_ready = 0 that cycle. The block is processed afterwards with the new key.
- Output backpressure: hold out_ready = 0 for 20 cycles -> out_valid stays 1 with stable out_block, and in_ready = 0 throughout.
- Stub peripheral never sets DONE, with TIMEOUT_CYCLES = 16 -> err = 1 after 16 wait cycles, FSM returns to IDLE, and out_valid stays 0. A later cfg accept clears err.

Source files
------------

// File: rtl/adam_aes_drv_pkg.sv
// Shared definitions for the ADAM AES stream driver: peripheral register
// offsets, register bit positions, fixed write values, word counts and the
// sequencer state encoding.
package adam_aes_drv_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  // Peripheral register offsets
  localparam logic [ADDR_W-1:0] REG_CTRL   = 8'h00;
  localparam logic [ADDR_W-1:0] REG_STATUS = 8'h04;
  localparam logic [ADDR_W-1:0] REG_CONFIG = 8'h08;
  localparam logic [ADDR_W-1:0] REG_ER     = 8'h0C;
  localparam logic [ADDR_W-1:0] REG_IER    = 8'h10;
  localparam logic [ADDR_W-1:0] REG_KEY    = 8'h14;
  localparam logic [ADDR_W-1:0] REG_BLOCK  = 8'h18;
  localparam logic [ADDR_W-1:0] REG_RESULT = 8'h1C;

  // Register bit positions
  localparam int unsigned CTRL_START_BIT   = 0;
  localparam int unsigned CTRL_ENABLE_BIT  = 1;
  localparam int unsigned STATUS_READY_BIT = 0;
  localparam int unsigned ER_DONE_BIT      = 0;
  localparam int unsigned CFG_ENCDEC_BIT   = 0;
  localparam int unsigned CFG_KEYLEN_BIT   = 1;

  // Fixed write values
  localparam logic [DATA_W-1:0] CTRL_GO     = 32'h0000_0003;  // START | ENABLE
  localparam logic [DATA_W-1:0] ER_DONE_W1C = 32'h0000_0001;
  localparam logic [DATA_W-1:0] IER_DONE_EN = 32'h0000_0001;

  localparam int unsigned KEY_WORDS   = 8;
  localparam int unsigned BLOCK_WORDS = 4;

  typedef enum logic [3:0] {
    IDLE,
    CFG,
    KEY,
    BLK,
    WAIT_RDY,
    START,
    WAIT_DONE,
    CLR,
    RES,
    OUT
  } drv_state_e;

endpackage

// File: rtl/adam_aes_stream_drv.sv
// Bus-master sequencer in front of the ADAM AES register peripheral.
// Turns a key/config handshake and a 128-bit input block stream into
// single-cycle register accesses, and returns each result on an output stream.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cfg_valid/cfg_ready          key/config handshake (cfg_key, cfg_keylen, cfg_encdec)
//   in_valid/in_ready, in_block  input block stream
//   out_valid/out_ready          result stream (out_block)
//   busy, err                    not-idle flag, sticky timeout flag
//   aes_cs/aes_we/aes_address/aes_write_data   registered peripheral access
//   aes_read_data                combinational read data
//   aes_irq                      peripheral interrupt
//
// Build option: define AES_DRV_IRQ_EN to enable the DONE interrupt (IER write
// during config) and wait on aes_irq instead of polling ER.
module adam_aes_stream_drv
  import adam_aes_drv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [255:0] cfg_key,
  input  logic         cfg_keylen,
  input  logic         cfg_encdec,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic         err,
  output logic         aes_cs,
  output logic         aes_we,
  output logic [7:0]   aes_address,
  output logic [31:0]  aes_write_data,
  input  logic [31:0]  aes_read_data,
  input  logic         aes_irq
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  drv_state_e state, state_nxt;
  logic [2:0]        wcnt, wcnt_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic              err_nxt;
  logic              cs_nxt, we_nxt;
  logic [7:0]        addr_nxt;
  logic [31:0]       wdata_nxt;
  logic [7:0][31:0]  key_q;
  logic [3:0][31:0]  blk_q, blk_src, res_q;
  logic              done_evt;

`ifdef AES_DRV_IRQ_EN
  assign done_evt = aes_irq;
`else
  logic unused_irq;
  assign unused_irq = aes_irq;
  assign done_evt   = aes_read_data[ER_DONE_BIT];
`endif

  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == IDLE) && !cfg_valid;
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign out_block = res_q;

  // The first BLOCK word goes out on the accept edge, before blk_q is loaded
  assign blk_src = (state == IDLE) ? in_block : blk_q;

  // Next state, counters, and the bus access to present in the next cycle
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    tcnt_nxt  = tcnt;
    err_nxt   = err;
    cs_nxt    = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = '0;
    wdata_nxt = '0;

    case (state)
      IDLE: begin
        if (cfg_valid) begin
          state_nxt = CFG;
          wcnt_nxt  = '0;
          err_nxt   = 1'b0;
        end else if (in_valid) begin
          state_nxt = BLK;
          wcnt_nxt  = '0;
        end
      end
      CFG: begin
`ifdef AES_DRV_IRQ_EN
        if (wcnt == 3'd0) begin
          wcnt_nxt = 3'd1;
        end else begin
          state_nxt = KEY;
          wcnt_nxt  = '0;
        end
`else
        state_nxt = KEY;
        wcnt_nxt  = '0;
`endif
      end
      KEY: begin
        if (wcnt == 3'(KEY_WORDS - 1)) state_nxt = IDLE;
        else                           wcnt_nxt  = wcnt + 3'd1;
      end
      BLK: begin
        if (wcnt == 3'(BLOCK_WORDS - 1)) begin
          state_nxt = WAIT_RDY;
          tcnt_nxt  = '0;
        end else begin
          wcnt_nxt = wcnt + 3'd1;
        end
      end
      WAIT_RDY: begin
        if (aes_read_data[STATUS_READY_BIT]) begin
          state_nxt = START;
        end else if (tcnt == T_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      START: begin
        state_nxt = WAIT_DONE;
        tcnt_nxt  = '0;
      end
      WAIT_DONE: begin
        if (done_evt) begin
          state_nxt = CLR;
        end else if (tcnt == T_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      CLR: begin
        state_nxt = RES;
        wcnt_nxt  = '0;
      end
      RES: begin
        if (wcnt == 3'(BLOCK_WORDS - 1)) state_nxt = OUT;
        else                             wcnt_nxt  = wcnt + 3'd1;
      end
      OUT: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Word index ~wcnt selects MSW first
    case (state_nxt)
      CFG: begin
        cs_nxt = 1'b1;
        we_nxt = 1'b1;
`ifdef AES_DRV_IRQ_EN
        if (wcnt_nxt != 3'd0) begin
          addr_nxt  = REG_IER;
          wdata_nxt = IER_DONE_EN;
        end else begin
          addr_nxt  = REG_CONFIG;
          wdata_nxt = {30'b0, cfg_keylen, cfg_encdec};
        end
`else
        addr_nxt  = REG_CONFIG;
        wdata_nxt = {30'b0, cfg_keylen, cfg_encdec};
`endif
      end
      KEY: begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = REG_KEY;
        wdata_nxt = key_q[~wcnt_nxt];
      end
      BLK: begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = REG_BLOCK;
        wdata_nxt = blk_src[~wcnt_nxt[1:0]];
      end
      WAIT_RDY: begin
        cs_nxt   = 1'b1;
        addr_nxt = REG_STATUS;
      end
      START: begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = REG_CTRL;
        wdata_nxt = CTRL_GO;
      end
      WAIT_DONE: begin
`ifndef AES_DRV_IRQ_EN
        cs_nxt   = 1'b1;
        addr_nxt = REG_ER;
`endif
      end
      CLR: begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = REG_ER;
        wdata_nxt = ER_DONE_W1C;
      end
      RES: begin
        cs_nxt   = 1'b1;
        addr_nxt = REG_RESULT;
      end
      default: ;
    endcase
  end

  // State, counters and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wcnt           <= '0;
      tcnt           <= '0;
      err            <= 1'b0;
      aes_cs         <= 1'b0;
      aes_we         <= 1'b0;
      aes_address    <= '0;
      aes_write_data <= '0;
    end else begin
      state          <= state_nxt;
      wcnt           <= wcnt_nxt;
      tcnt           <= tcnt_nxt;
      err            <= err_nxt;
      aes_cs         <= cs_nxt;
      aes_we         <= we_nxt;
      aes_address    <= addr_nxt;
      aes_write_data <= wdata_nxt;
    end
  end

  // Payload capture: key and block on accept, result words during RES
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q <= '0;
      blk_q <= '0;
      res_q <= '0;
    end else begin
      if (state == IDLE && cfg_valid)              key_q <= cfg_key;
      if (state == IDLE && !cfg_valid && in_valid) blk_q <= in_block;
      if (state == RES)                            res_q[~wcnt[1:0]] <= aes_read_data;
    end
  end

endmodule

// File: tb/tb_adam_aes_stream_drv.sv
// Directed bench for adam_aes_stream_drv with a small register-level model of
// the AES peripheral (known-answer table for the FIPS-197 AES-128 vector,
// simple XOR transform otherwise).
module tb_adam_aes_stream_drv;

  localparam int unsigned TO = 16;
  localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2_HI = 128'ha0a0a0a0a0a0a0a0a0a0a0a0a0a0a0a0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_valid, cfg_ready, cfg_keylen, cfg_encdec;
  logic [255:0] cfg_key;
  logic         in_valid, in_ready;
  logic [127:0] in_block;
  logic         out_valid, out_ready;
  logic [127:0] out_block;
  logic         busy, err;
  logic         aes_cs, aes_we;
  logic [7:0]   aes_address;
  logic [31:0]  aes_write_data;
  logic [31:0]  aes_read_data;
  logic         aes_irq;

  int n_checks = 0;
  int n_errors = 0;

  adam_aes_stream_drv #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key),
    .cfg_keylen(cfg_keylen), .cfg_encdec(cfg_encdec),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .busy(busy), .err(err),
    .aes_cs(aes_cs), .aes_we(aes_we), .aes_address(aes_address),
    .aes_write_data(aes_write_data), .aes_read_data(aes_read_data),
    .aes_irq(aes_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  logic [31:0]      m_cfg;
  logic [7:0][31:0] m_key;
  logic [3:0][31:0] m_blk;
  logic [3:0][31:0] m_res;
  logic [2:0]       m_kidx;
  logic [1:0]       m_bidx, m_ridx;
  logic             m_done;
  int               m_dcnt;
  logic             m_stub = 1'b0;
  int               done_lat = 3;

  function automatic logic [127:0] model_aes(input logic [127:0] k, input logic [31:0] cf,
                                             input logic [127:0] b);
    if (!cf[1] && k == FIPS_K && cf[0] && b == FIPS_PT) return FIPS_CT;
    if (!cf[1] && k == FIPS_K && !cf[0] && b == FIPS_CT) return FIPS_PT;
    return b ^ k ^ {128{cf[0]}};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cfg <= '0; m_key <= '0; m_blk <= '0; m_res <= '0;
      m_kidx <= '0; m_bidx <= '0; m_ridx <= '0; m_done <= 1'b0; m_dcnt <= 0;
    end else begin
      if (m_dcnt != 0) begin
        m_dcnt <= m_dcnt - 1;
        if (m_dcnt == 1) m_done <= 1'b1;
      end
      if (aes_cs && aes_we) begin
        case (aes_address)
          8'h00: if (aes_write_data[0]) begin
            m_kidx <= '0; m_bidx <= '0; m_ridx <= '0;
            m_dcnt <= m_stub ? 0 : done_lat;
            m_res  <= model_aes(m_key[7:4], m_cfg, m_blk);
          end
          8'h08: m_cfg <= aes_write_data;
          8'h0C: if (aes_write_data[0]) m_done <= 1'b0;
          8'h14: begin m_key[3'd7 - m_kidx] <= aes_write_data; m_kidx <= m_kidx + 3'd1; end
          8'h18: begin m_blk[2'd3 - m_bidx] <= aes_write_data; m_bidx <= m_bidx + 2'd1; end
          default: ;
        endcase
      end
      if (aes_cs && !aes_we && aes_address == 8'h1C) m_ridx <= m_ridx + 2'd1;
    end
  end

  always_comb begin
    aes_read_data = 32'h0;
    if (aes_cs && !aes_we) begin
      case (aes_address)
        8'h04:   aes_read_data = 32'h1;
        8'h0C:   aes_read_data = {31'h0, m_done};
        8'h1C:   aes_read_data = m_res[2'd3 - m_ridx];
        default: aes_read_data = 32'h0;
      endcase
    end
  end

  assign aes_irq = m_done;

  // ---------------- bus monitor ----------------
  logic [40:0] trace_q[$];
  int          er_viol = 0;
  logic        er_clr = 1'b0;

  always @(posedge clk) begin
    if (reset_n && aes_cs) begin
      trace_q.push_back({aes_we, aes_address, aes_we ? aes_write_data : 32'h0});
      if (aes_we && aes_address == 8'h00 && aes_write_data[0]) er_clr <= 1'b0;
      if (aes_we && aes_address == 8'h0C && aes_write_data[0]) er_clr <= 1'b1;
      if (!aes_we && aes_address == 8'h1C && !er_clr) er_viol <= er_viol + 1;
    end
  end

  // ---------------- drivers ----------------
  task automatic do_cfg(input logic [255:0] k, input logic kl, input logic ed,
                        output int busy_cyc, output logic [41:0] first_acc);
    int n;
    @(negedge clk);
    cfg_key = k; cfg_keylen = kl; cfg_encdec = ed; cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    first_acc = {aes_cs, aes_we, aes_address, aes_write_data};
    busy_cyc = 0;
    while (busy && busy_cyc < 200) begin busy_cyc++; @(posedge clk); #1; end
  endtask

  task automatic run_block(input logic [127:0] b, output int lat, output logic [127:0] res);
    int n;
    @(negedge clk);
    in_block = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    res = out_block;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0][31:0] kw;
    logic [3:0][31:0] pw;
    logic [40:0]      exp_q[$];
    logic [41:0]      fa;
    logic [127:0]     res, hold;
    int bc, lat, n, ovs, viol, er0, er_reads, cfg_cyc;

    reset_n = 1'b0; cfg_valid = 1'b0; cfg_key = '0; cfg_keylen = 1'b0; cfg_encdec = 1'b0;
    in_valid = 1'b0; in_block = '0; out_ready = 1'b1;
    kw = {FIPS_K, 128'h0};
    pw = FIPS_PT;
`ifdef AES_DRV_IRQ_EN
    cfg_cyc = 10;
`else
    cfg_cyc = 9;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {aes_cs, aes_we, aes_address, aes_write_data, cfg_ready, in_ready,
                         out_valid, busy, err}, {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_out_block", out_block, 128'h0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", {busy, aes_cs}, 2'b00);

    // FIPS-197 encrypt with full bus trace
    trace_q.delete();
    er0 = er_viol;
    do_cfg({FIPS_K, 128'h0}, 1'b0, 1'b1, bc, fa);
    check("cfg_first_access", fa, {1'b1, 1'b1, 8'h08, 32'h1});
    check("cfg_busy_cycles", bc, cfg_cyc);
    run_block(FIPS_PT, lat, res);
    check("enc_result", res, FIPS_CT);
    check("enc_latency", lat, 16);

    exp_q.push_back({1'b1, 8'h08, 32'h1});
`ifdef AES_DRV_IRQ_EN
    exp_q.push_back({1'b1, 8'h10, 32'h1});
`endif
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 8'h14, kw[3'(7 - i)]});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h18, pw[2'(3 - i)]});
    exp_q.push_back({1'b0, 8'h04, 32'h0});
    exp_q.push_back({1'b1, 8'h00, 32'h3});
`ifndef AES_DRV_IRQ_EN
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h0C, 32'h0});
`endif
    exp_q.push_back({1'b1, 8'h0C, 32'h1});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h1C, 32'h0});
    check("trace_len", trace_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < trace_q.size(); i++)
      check($sformatf("trace[%0d]", i), trace_q[i], exp_q[i]);
    check("er_before_result", er_viol - er0, 0);

    // Decrypt with the same key
    do_cfg({FIPS_K, 128'h0}, 1'b0, 1'b0, bc, fa);
    check("dec_cfg_write", fa, {1'b1, 1'b1, 8'h08, 32'h0});
    run_block(FIPS_CT, lat, res);
    check("dec_result", res, FIPS_PT);

    // Simultaneous cfg and block: cfg wins, block uses the new key
    @(negedge clk);
    cfg_key = {KEY2_HI, 128'h0}; cfg_keylen = 1'b0; cfg_encdec = 1'b1; cfg_valid = 1'b1;
    in_block = 128'h0; in_valid = 1'b1;
    #1;
    check("simul_in_ready", in_ready, 1'b0);
    check("simul_cfg_ready", cfg_ready, 1'b1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("simul_cfg_first", {aes_cs, aes_we, aes_address}, {1'b1, 1'b1, 8'h08});
    run_block(128'h0, lat, res);
    check("simul_result", res, 128'h5f5f5f5f5f5f5f5f5f5f5f5f5f5f5f5f);

    // Output backpressure for 20 cycles
    out_ready = 1'b0;
    run_block(FIPS_PT, lat, res);
    check("bp_result", res, 128'h5f4e7d6c1b0a3928d7c6f5e49382b1a0);
    hold = res;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_block !== hold || in_ready || cfg_ready) viol++;
    end
    check("bp_stable", viol, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {out_valid, busy}, 2'b00);

    // Timeout: DONE never arrives
    m_stub = 1'b1;
    trace_q.delete();
    @(negedge clk);
    in_block = FIPS_PT; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1; ovs = 0;
    while (busy && n < 300) begin
      if (out_valid) ovs++;
      @(posedge clk); #1;
      n++;
    end
    check("to_cycles", n, 7 + TO);
    check("to_err", err, 1'b1);
    check("to_no_output", ovs, 0);
    er_reads = 0;
    foreach (trace_q[i]) if (trace_q[i][40:32] == {1'b0, 8'h0C}) er_reads++;
`ifdef AES_DRV_IRQ_EN
    check("to_er_polls", er_reads, 0);
`else
    check("to_er_polls", er_reads, TO);
`endif
    m_stub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("to_err_sticky", err, 1'b1);

    // New cfg clears err; next block runs normally
    do_cfg({FIPS_K, 128'h0}, 1'b0, 1'b1, bc, fa);
    check("err_cleared", err, 1'b0);
    run_block(FIPS_PT, lat, res);
    check("recover_result", res, FIPS_CT);

    // Reset mid-operation
    @(negedge clk);
    in_block = FIPS_PT; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", {busy, aes_cs, out_valid, cfg_ready}, 4'b0001);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_quiet", {busy, aes_cs, out_valid}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
